// File: rtl/object_scan_renderer.sv
// Object sprite sweep: issues (y, distance) colour queries in raster order and
// turns each response into one VGA pixel write. Optional macro: SKIP_TRANSPARENT_EN.
module object_scan_renderer #(
  parameter int         Y_TOP         = 60,
  parameter int         Y_BOTTOM      = 119,
  parameter int         WIDTH         = 16,
  parameter int         QUERY_LATENCY = 1,
  parameter int         SCREEN_W      = 160,
  parameter logic [2:0] TRANSPARENT   = 3'b011
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] base_x,
  output logic [6:0] obj_y,
  output logic [3:0] obj_distance,
  input  logic [2:0] obj_colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int CW = (QUERY_LATENCY > 1) ? $clog2(QUERY_LATENCY) : 1;
`ifdef SKIP_TRANSPARENT_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_QUERY, S_WAIT, S_PLOT, S_DONE} state_t;

  state_t          state_reg, state_next;
  logic [7:0]      base_reg;
  logic [6:0]      y_reg;
  logic [3:0]      dist_reg;
  logic [CW-1:0]   cnt_reg;
  logic [8:0]      x_sum_reg;
  logic [6:0]      vga_y_reg;
  logic [2:0]      colour_reg;

  logic last_wait, last_col, last_row, clipped, skipped;

  assign last_wait = (cnt_reg == CW'(QUERY_LATENCY - 1));
  assign last_col  = (dist_reg == 4'(WIDTH - 1));
  assign last_row  = (y_reg == 7'(Y_BOTTOM));
  // The sum is kept 9 bits wide so that columns past the right edge clip
  // instead of wrapping back onto the screen.
  assign clipped   = (x_sum_reg >= 9'(SCREEN_W));
  assign skipped   = SKIP_EN && (colour_reg == TRANSPARENT);

  always_ff @(posedge clock) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_QUERY;
      S_QUERY: state_next = S_WAIT;
      S_WAIT:  if (last_wait) state_next = S_PLOT;
      S_PLOT:  state_next = (last_col && last_row) ? S_DONE : S_QUERY;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    plot = 1'b0;
    busy = 1'b1;
    done = 1'b0;
    case (state_reg)
      S_IDLE:  busy = 1'b0;
      S_PLOT:  plot = !clipped && !skipped;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      base_reg   <= '0;
      y_reg      <= 7'(Y_TOP);
      dist_reg   <= '0;
      cnt_reg    <= '0;
      x_sum_reg  <= '0;
      vga_y_reg  <= '0;
      colour_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: if (start) begin
          base_reg <= base_x;
          y_reg    <= 7'(Y_TOP);
          dist_reg <= '0;
        end
        S_QUERY: cnt_reg <= '0;
        S_WAIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          // Response and pixel coordinates are captured together so they
          // stay aligned through the whole PLOT cycle.
          if (last_wait) begin
            colour_reg <= obj_colour;
            x_sum_reg  <= {1'b0, base_reg} + {5'b0, dist_reg};
            vga_y_reg  <= y_reg;
          end
        end
        S_PLOT: if (!(last_col && last_row)) begin
          if (last_col) begin
            dist_reg <= '0;
            y_reg    <= y_reg + 1'b1;
          end else begin
            dist_reg <= dist_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign obj_y        = y_reg;
  assign obj_distance = dist_reg;
  assign vga_x        = x_sum_reg[7:0];
  assign vga_y        = vga_y_reg;
  assign vga_colour   = colour_reg;

endmodule
